parallel_counters: RTL and testbench

//  Population-count compressors for the multiplier partial-product reduction trees.
//  - 3:2 counter: returns the number of set bits in a 3-bit column slice.
//  - 7:3 counter: returns the number of set bits in a 7-bit column slice.
//  - Each count has a combinational output and a registered copy for pipelined trees.

---
 rtl/parallel_counters.sv | 64 ++++++
 tb/tb_parallel_counters.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/parallel_counters.sv
// parallel_counters
//   Population-count compressors for multiplier partial-product reduction trees.
//   A 3:2 counter (one full adder) and a 7:3 counter (four full adders).
//   Each count is available combinationally and as a registered copy.
//
// Ports
//   clk     in   1  clock, registers update on the rising edge
//   rst     in   1  synchronous active-high reset, clears the registered counts
//   in3     in   3  3:2 counter input bits
//   cnt3    out  2  combinational popcount of in3
//   in7     in   7  7:3 counter input bits
//   cnt7    out  3  combinational popcount of in7
//   cnt3_q  out  2  cnt3 delayed by one clock
//   cnt7_q  out  3  cnt7 delayed by one clock
module parallel_counters (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in3,
    output logic [1:0] cnt3,
    input  logic [6:0] in7,
    output logic [2:0] cnt7,
    output logic [1:0] cnt3_q,
    output logic [2:0] cnt7_q
);

    // Full adder: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [1:0] fa0;
    logic [1:0] fa1;
    logic [1:0] fa2;
    logic [1:0] fa3;
    logic [1:0] cnt3_d;
    logic [2:0] cnt7_d;

    // 3:2 counter is a single full adder: sum is the LSB, carry the MSB.
    assign cnt3 = full_add(in3[0], in3[1], in3[2]);

    // 7:3 counter: two first-level adders produce weight-1 sums and weight-2
    // carries. The weight-1 sums merge with in7[6]; all weight-2 carries then
    // merge in the last adder, whose carry is the weight-4 bit.
    assign fa0  = full_add(in7[0], in7[1], in7[2]);
    assign fa1  = full_add(in7[3], in7[4], in7[5]);
    assign fa2  = full_add(fa0[0], fa1[0], in7[6]);
    assign fa3  = full_add(fa0[1], fa1[1], fa2[1]);
    assign cnt7 = {fa3[1], fa3[0], fa2[0]};

    always_comb begin
        cnt3_d = cnt3;
        cnt7_d = cnt7;
        if (rst) begin
            cnt3_d = 2'd0;
            cnt7_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        cnt3_q <= cnt3_d;
        cnt7_q <= cnt7_d;
    end

endmodule

// File: tb/tb_parallel_counters.sv
// tb_parallel_counters
//   Directed bench for parallel_counters: exhaustive combinational counts,
//   registered latency, reset priority, streaming and input independence.
module tb_parallel_counters;

    logic       clk;
    logic       rst;
    logic [2:0] in3;
    logic [1:0] cnt3;
    logic [6:0] in7;
    logic [2:0] cnt7;
    logic [1:0] cnt3_q;
    logic [2:0] cnt7_q;

    int n_cmp;
    int n_bad;

    parallel_counters dut (
        .clk    (clk),
        .rst    (rst),
        .in3    (in3),
        .cnt3   (cnt3),
        .in7    (in7),
        .cnt7   (cnt7),
        .cnt3_q (cnt3_q),
        .cnt7_q (cnt7_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    function automatic int popcount(input logic [6:0] v);
        int n;
        n = 0;
        for (int b = 0; b < 7; b++) n += int'(v[b]);
        return n;
    endfunction

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        in3   = 3'b111;
        in7   = 7'h7F;

        // Reset state
        step();
        step();
        check("reset_cnt3_q", 8'(cnt3_q), 8'd0);
        check("reset_cnt7_q", 8'(cnt7_q), 8'd0);
        check("reset_cnt7_comb", 8'(cnt7), 8'd7);

        @(negedge clk);
        rst = 1'b0;

        // Directed boundary and example values
        in3 = 3'b000; in7 = 7'b0000000; #1;
        check("zero_cnt3", 8'(cnt3), 8'd0);
        check("zero_cnt7", 8'(cnt7), 8'd0);
        in3 = 3'b101; in7 = 7'b1010101; #1;
        check("cnt3_101", 8'(cnt3), 8'b10);
        check("cnt7_1010101", 8'(cnt7), 8'b100);
        in3 = 3'b111; in7 = 7'b0111111; #1;
        check("cnt3_111", 8'(cnt3), 8'b11);
        check("cnt7_0111111", 8'(cnt7), 8'b110);
        in7 = 7'b1111111; #1;
        check("cnt7_1111111", 8'(cnt7), 8'b111);

        // Exhaustive 3:2
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in3 = 3'(i);
            #1;
            check("exh_cnt3", 8'(cnt3), 8'(popcount({4'b0, 3'(i)})));
        end

        // Exhaustive 7:3
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            in7 = 7'(i);
            #1;
            check("exh_cnt7", 8'(cnt7), 8'(popcount(7'(i))));
        end

        // Registered path: known previous value, then one-edge latency
        @(negedge clk);
        in3 = 3'b000; in7 = 7'b0000000;
        step();
        @(negedge clk);
        in3 = 3'b011; in7 = 7'b1111111;
        #1;
        check("reg_before_cnt7_q", 8'(cnt7_q), 8'd0);
        check("reg_before_cnt3_q", 8'(cnt3_q), 8'd0);
        step();
        check("reg_after_cnt7_q", 8'(cnt7_q), 8'b111);
        check("reg_after_cnt3_q", 8'(cnt3_q), 8'b10);

        // Reset mid-operation, then release
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rst_cnt7_q", 8'(cnt7_q), 8'b000);
        check("rst_cnt3_q", 8'(cnt3_q), 8'b00);
        check("rst_cnt7_comb", 8'(cnt7), 8'b111);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rel_cnt7_q", 8'(cnt7_q), 8'b111);
        check("rel_cnt3_q", 8'(cnt3_q), 8'b10);

        // Back-to-back streaming of thermometer codes
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in7 = 7'((8'd1 << k) - 8'd1);
            step();
            check("stream_cnt7_q", 8'(cnt7_q), 8'(k));
        end

        // Independence: in3 held while in7 toggles
        @(negedge clk);
        in3 = 3'b110;
        step();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in7 = (k % 2 == 0) ? 7'b1010101 : 7'b0101010;
            step();
            check("indep_cnt3", 8'(cnt3), 8'd2);
            check("indep_cnt3_q", 8'(cnt3_q), 8'd2);
            check("indep_cnt7_q", 8'(cnt7_q), (k % 2 == 0) ? 8'd4 : 8'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
